// File: rtl/semaforo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | semaforo_pkg                                                         |
// | Phase encoding and lamp patterns shared by the traffic-light block.  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package semaforo_pkg;

  typedef enum logic [2:0] {
    A_GREEN  = 3'd0,
    A_YELLOW = 3'd1,
    RED_TO_B = 3'd2,
    B_GREEN  = 3'd3,
    B_YELLOW = 3'd4,
    RED_TO_A = 3'd5
  } phase_t;

  typedef struct packed {
    logic vda;
    logic ama;
    logic vma;
    logic vdb;
    logic amb;
    logic vmb;
  } lamps_t;

  // Field order: {VDA, AMA, VMA, VDB, AMB, VMB}
  localparam lamps_t c_lamps_a_green  = 6'b100_001;
  localparam lamps_t c_lamps_a_yellow = 6'b010_001;
  localparam lamps_t c_lamps_all_red  = 6'b001_001;
  localparam lamps_t c_lamps_b_green  = 6'b001_100;
  localparam lamps_t c_lamps_b_yellow = 6'b001_010;

  function automatic lamps_t lamps_of(input phase_t p);
    lamps_t l;
    case (p)
      A_GREEN:  l = c_lamps_a_green;
      A_YELLOW: l = c_lamps_a_yellow;
      B_GREEN:  l = c_lamps_b_green;
      B_YELLOW: l = c_lamps_b_yellow;
      default:  l = c_lamps_all_red;
    endcase
    return l;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/semaforo_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | semaforo_timer                                                       |
// | Tick-driven interval counter that saturates at a programmable limit. |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module semaforo_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             tick,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             done
);

  logic [WIDTH-1:0] r_count;
  logic             w_done;

  assign w_done = (r_count == limit);

  // Clear wins over tick so every phase starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (tick && !w_done) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;
  assign done  = w_done;

endmodule
`default_nettype wire

// File: rtl/semaforo_sequenciador.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | semaforo_sequenciador                                                |
// | Timed green/yellow/all-red sequencer for two crossing roads.         |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module semaforo_sequenciador
  import semaforo_pkg::*;
#(
  parameter int MIN_GREEN = 8,
  parameter int YELLOW    = 3,
  parameter int ALL_RED   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       req_a,
  input  logic       req_b,
  output logic       VDA,
  output logic       AMA,
  output logic       VMA,
  output logic       VDB,
  output logic       AMB,
  output logic       VMB,
  output logic [2:0] phase
);

  localparam int c_tmr_w = $clog2(max3(MIN_GREEN, YELLOW, ALL_RED) + 1);

  localparam logic [c_tmr_w-1:0] c_lim_green  = c_tmr_w'(MIN_GREEN - 1);
  localparam logic [c_tmr_w-1:0] c_lim_yellow = c_tmr_w'(YELLOW - 1);
  localparam logic [c_tmr_w-1:0] c_lim_red    = c_tmr_w'(ALL_RED - 1);

  phase_t               r_state;
  phase_t               w_next;
  logic                 w_clear;
  logic [c_tmr_w-1:0]   w_limit;
  logic [c_tmr_w-1:0]   w_count;
  logic                 w_done;
  logic                 w_a_only;
  logic                 w_b_only;
  lamps_t               w_lamps;

  assign w_a_only = req_a & ~req_b;
  assign w_b_only = req_b & ~req_a;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RED_TO_A;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_limit = c_lim_red;
    case (r_state)
      A_GREEN, B_GREEN:   w_limit = c_lim_green;
      A_YELLOW, B_YELLOW: w_limit = c_lim_yellow;
      default:            w_limit = c_lim_red;
    endcase
  end

  // Green phases only yield to an exclusive request from the other road;
  // yellow and all-red run out unconditionally.
  always_comb begin
    w_next = r_state;
    if (tick && w_done) begin
      case (r_state)
        A_GREEN:  if (w_b_only) w_next = A_YELLOW;
        A_YELLOW: w_next = RED_TO_B;
        RED_TO_B: w_next = B_GREEN;
        B_GREEN:  if (w_a_only) w_next = B_YELLOW;
        B_YELLOW: w_next = RED_TO_A;
        RED_TO_A: w_next = A_GREEN;
        default:  w_next = RED_TO_A;
      endcase
    end
  end

  assign w_clear = (w_next != r_state);

  semaforo_timer #(
    .WIDTH (c_tmr_w)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (w_clear),
    .tick  (tick),
    .limit (w_limit),
    .count (w_count),
    .done  (w_done)
  );

  assign w_lamps = lamps_of(r_state);

  assign VDA   = w_lamps.vda;
  assign AMA   = w_lamps.ama;
  assign VMA   = w_lamps.vma;
  assign VDB   = w_lamps.vdb;
  assign AMB   = w_lamps.amb;
  assign VMB   = w_lamps.vmb;
  assign phase = r_state;

  logic w_unused;
  assign w_unused = ^w_count;

endmodule
`default_nettype wire

// File: doc/semaforo_sequenciador.md
Name: semaforo_sequenciador

Overview:
Timed traffic-light sequencer sitting directly downstream of the combinational right-of-way decoder for crossing roads A and B. It consumes the decoder's green requests for A and B and drives the physical lamps. It inserts minimum-green, yellow and all-red intervals so the lamps never switch instantly from green on one road to green on the other. Time base is an external one-cycle `tick` strobe (1 Hz in the board build).

Parameters:
- MIN_GREEN, 8: minimum ticks a road stays green before yielding; must be ≥1.
- YELLOW, 3: ticks spent in yellow; must be ≥1.
- ALL_RED, 1: ticks both roads are red between phases; must be ≥1.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- tick  in  1  time-base strobe; one-cycle pulse; timers advance only when high.
- req_a  in  1  A wants green (decoder VDA).
- req_b  in  1  B wants green (decoder VDB).
- VDA  out  1  A green lamp.
- AMA  out  1  A yellow lamp.
- VMA  out  1  A red lamp.
- VDB  out  1  B green lamp.
- AMB  out  1  B yellow lamp.
- VMB  out  1  B red lamp.
- phase  out  3  current state encoding, for debug and 7-segment display.

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset:
  - State goes to RED_TO_A with timer = 0.
  - Outputs: VMA = 1, VMB = 1, all others 0, phase = RED_TO_A.
  - Asserting reset mid-operation forces this state immediately, independent of the clock.
- States: A_GREEN, A_YELLOW, RED_TO_B, B_GREEN, B_YELLOW, RED_TO_A.
- Lamp decode (Moore, outputs depend only on the state register):
  - A_GREEN: VDA, VMB.
  - A_YELLOW: AMA, VMB.
  - RED_TO_B and RED_TO_A: VMA, VMB.
  - B_GREEN: VDB, VMA.
  - B_YELLOW: AMB, VMA.
  - Exactly one lamp per road is lit at all times.
  - No state ever lights a green or yellow on both roads.
- Timer:
  - Width is $clog2(max(MIN_GREEN, YELLOW, ALL_RED) + 1).
  - Cleared to 0 on every state entry.
  - Increments only on cycles with tick = 1.
  - In the green states it saturates at MIN_GREEN-1.
  - It never wraps.
- Transitions are evaluated only when tick = 1. The new state is visible on the edge of that tick cycle.
  - A_GREEN → A_YELLOW when timer == MIN_GREEN-1 and req_b = 1 and req_a = 0.
  - A_YELLOW → RED_TO_B when timer == YELLOW-1.
  - RED_TO_B → B_GREEN when timer == ALL_RED-1.
  - B_GREEN → B_YELLOW when timer == MIN_GREEN-1 and req_a = 1 and req_b = 0.
  - B_YELLOW → RED_TO_A when timer == YELLOW-1.
  - RED_TO_A → A_GREEN when timer == ALL_RED-1.
- Request rules:
  - req_a = req_b = 1 is invalid; req_a = req_b = 0 means no demand. In both cases the green road holds indefinitely.
  - Requests are sampled only in the green states.
  - Yellow and all-red phases always run to completion, even if the request drops.
- tick = 0: state and timer are frozen.
- Latency: a request present from green entry yields the other road's green after MIN_GREEN + YELLOW + ALL_RED ticks.

Decomposition:
- Package semaforo_pkg holds:
  - `typedef enum logic [2:0] phase_t` with the six states; phase outputs this encoding.
  - Lamp-pattern constants for each state.
- One sub-module, semaforo_timer:
  - Parameterized width.
  - Inputs: clear, tick, saturation limit.
  - Outputs: the count and a `done` flag (count == limit).

Test Plan:
Common configuration: MIN_GREEN=4, YELLOW=2, ALL_RED=1.
- Reset then tick every cycle, req_a=1, req_b=0:
  - During reset: VMA=VMB=1, others 0.
  - One tick after release: VDA=1, VMB=1; this state holds for 100 cycles.
- From A_GREEN entry, hold req_b=1, req_a=0, tick every cycle:
  - 4 cycles VDA, then 2 cycles AMA, then 1 cycle VMA+VMB, then VDB=1, VMA=1 on cycle 7.
- req_b pulses high for one tick during A_YELLOW then drops:
  - Sequence still completes to B_GREEN; B then holds green.
- req_a=req_b=1 in B_GREEN for 50 ticks:
  - VDB stays 1; phase stays B_GREEN.
- tick every 5th cycle:
  - Every interval lasts exactly 5× its tick count in cycles.
  - With tick held low, state and lamps are frozen.
- rst_n dropped asynchronously mid-A_YELLOW, between clock edges:
  - VMA=VMB=1 before the next edge.
  - After release, the A_GREEN sequence restarts.
